// File: rtl/mips_ctrl.sv
// mips_ctrl: multi-cycle sequencer for a small MIPS-like core.
// Each instruction is fetched, decoded, executed and written back over four
// or more cycles. The controller drives the register file, data memory and
// stack strobes. The ALU and all datapaths live outside this block.
// Optional build macro: MIPS_CTRL_FAULT_EN. When defined, stack
// overflow/underflow and opcodes above 0x0B trap into FAULT, which only rst
// leaves. When undefined, SP wraps and those opcodes behave as NOOP.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start, all outputs quiet
// S_FETCH  | imem_req held at PC until imem_ack, IR captured on ack
// S_DECODE | IR fields presented to register file / ALU
// S_EXEC   | data-memory or stack strobe, SP update
// S_WB     | register write strobe, PC update
// S_FAULT  | trapped, sticky until rst
module mips_ctrl #(
  parameter int PC_W = 5,
  parameter int SP_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [3:0]      rf_raddr1,
  output logic [3:0]      rf_raddr2,
  input  logic [31:0]     rf_rdata2,
  output logic [1:0]      alu_op,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [1:0]      rf_wsel,
  output logic [7:0]      imm,
  output logic [4:0]      dmem_addr,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [SP_W-1:0] stk_addr,
  output logic            stk_re,
  output logic            stk_we,
  output logic            busy,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_FAULT
  } state_t;

  localparam logic [7:0] OP_NOOP = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_LDNM = 8'h02;
  localparam logic [7:0] OP_STR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_JMP  = 8'h08;
  localparam logic [7:0] OP_JMP0 = 8'h09;
  localparam logic [7:0] OP_PUSH = 8'h0A;
  localparam logic [7:0] OP_POP  = 8'h0B;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [31:0]       ir_q, ir_d;

  logic [7:0]        op, dest, src1, src2;
  logic [PC_W-1:0]   jmp_tgt;
  logic              trap;
  logic              unused_ir;

  assign op      = ir_q[31:24];
  assign dest    = ir_q[23:16];
  assign src1    = ir_q[15:8];
  assign src2    = ir_q[7:0];
  assign jmp_tgt = PC_W'(dest);
  // src1[7:4] is architecturally ignored; fold the IR into one sink bit.
  assign unused_ir = ^ir_q;

`ifdef MIPS_CTRL_FAULT_EN
  // Trap conditions are evaluated in EXEC before any strobe is raised.
  assign trap  = ((op == OP_PUSH) && (sp_q == '1)) ||
                 ((op == OP_POP)  && (sp_q == '0)) ||
                 (op > OP_POP);
  assign fault = (state_q == S_FAULT);
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign busy      = (state_q != S_IDLE);

  // State, PC, SP and instruction register; rst clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic and all strobes; everything defaults to idle/zero.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    ir_d      = ir_q;
    imem_req  = 1'b0;
    rf_raddr1 = 4'd0;
    rf_raddr2 = 4'd0;
    alu_op    = 2'd0;
    imm       = 8'd0;
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    rf_wsel   = 2'd0;
    dmem_addr = 5'd0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    stk_addr  = '0;
    stk_re    = 1'b0;
    stk_we    = 1'b0;

    if ((state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_WB)) begin
      rf_raddr1 = src1[3:0];
      rf_raddr2 = src2[3:0];
      alu_op    = op[1:0];
      imm       = src2;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (trap) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_WB;
          case (op)
            OP_LOAD: begin
              dmem_re   = 1'b1;
              dmem_addr = src2[4:0];
            end
            OP_STR: begin
              dmem_we   = 1'b1;
              dmem_addr = dest[4:0];
            end
            OP_PUSH: begin
              stk_we   = 1'b1;
              stk_addr = sp_q;
              sp_d     = sp_q + SP_ONE;
            end
            OP_POP: begin
              stk_re   = 1'b1;
              stk_addr = sp_q - SP_ONE;
              sp_d     = sp_q - SP_ONE;
            end
            default: ;
          endcase
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        rf_waddr = dest[3:0];
        case (op)
          OP_LOAD: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd1;
          end
          OP_LDNM: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd2;
          end
          OP_ADD, OP_SUB, OP_XOR, OP_AND: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd0;
          end
          OP_POP: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd3;
          end
          default: ;
        endcase
        if (op == OP_JMP) begin
          pc_d = jmp_tgt;
        end else if ((op == OP_JMP0) && (rf_rdata2 != 32'd0)) begin
          pc_d = jmp_tgt;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_ctrl.sv
// Bench for mips_ctrl: a directed vector table, a reset-abort sequence,
// and randomized instructions checked against an instruction-level model.
module tb_mips_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] rf_rdata2 = 32'd0;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [1:0]  alu_op, rf_wsel;
  logic        rf_we, dmem_re, dmem_we, stk_re, stk_we, busy, fault;
  logic [7:0]  imm;
  logic [4:0]  dmem_addr;
  logic [4:0]  stk_addr;
  logic [4:0]  strb;

  mips_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata2(rf_rdata2), .alu_op(alu_op), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .imm(imm),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .stk_addr(stk_addr), .stk_re(stk_re), .stk_we(stk_we),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  assign strb = {dmem_re, dmem_we, stk_re, stk_we, rf_we};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r2;
    int          dly;
    logic [3:0]  ex_strb;   // {dmem_re, dmem_we, stk_re, stk_we}
    int          ex_addr;
    logic        wb_we;
    logic [1:0]  wsel;
    logic [3:0]  waddr;
    int          npc;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;
  int m_sp   = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"},
        64'({busy, fault, imem_req, imem_addr, strb, rf_raddr1, rf_raddr2,
             alu_op, imm, rf_waddr, rf_wsel, dmem_addr, stk_addr}),
        64'd0);
  endtask

  task automatic chk_fields(input logic [31:0] ins, input string tag);
    chk({tag, "_raddr1"}, 64'(rf_raddr1), 64'(ins[11:8]));
    chk({tag, "_raddr2"}, 64'(rf_raddr2), 64'(ins[3:0]));
    chk({tag, "_imm"},    64'(imm),       64'(ins[7:0]));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_pc = 0;
    m_sp   = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_idle(tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_rel"});
  endtask

  // Instruction-level model: expected strobes, write-back and next PC.
  task automatic model(input logic [31:0] ins, input logic [31:0] r2,
                       input int dly, output vec_t v);
    int op, dest, s2;
    op   = int'(ins[31:24]);
    dest = int'(ins[23:16]);
    s2   = int'(ins[7:0]);
    v.instr = ins; v.r2 = r2; v.dly = dly;
    v.ex_strb = 4'b0000; v.ex_addr = 0;
    v.wb_we = 1'b0; v.wsel = 2'd0; v.waddr = 4'(dest % 16);
    v.npc = (exp_pc + 1) % 32;
    case (op)
      1: begin v.ex_strb = 4'b1000; v.ex_addr = s2 % 32; v.wb_we = 1'b1; v.wsel = 2'd1; end
      2: begin v.wb_we = 1'b1; v.wsel = 2'd2; end
      3: begin v.ex_strb = 4'b0100; v.ex_addr = dest % 32; end
      4, 5, 6, 7: begin v.wb_we = 1'b1; v.wsel = 2'd0; end
      8: v.npc = dest % 32;
      9: if (r2 != 32'd0) v.npc = dest % 32;
      10: begin v.ex_strb = 4'b0001; v.ex_addr = m_sp; m_sp = (m_sp + 1) % 32; end
      11: begin
        v.ex_strb = 4'b0010; m_sp = (m_sp + 31) % 32; v.ex_addr = m_sp;
        v.wb_we = 1'b1; v.wsel = 2'd3;
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input vec_t v);
    rf_rdata2 = v.r2;
    for (int k = 0; k <= v.dly; k++) begin
      chk("fetch_req",  64'(imem_req),  64'd1);
      chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
      chk("fetch_strb", 64'(strb),      64'd0);
      imem_ack   = (k == v.dly);
      imem_rdata = (k == v.dly) ? v.instr : $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    chk_fields(v.instr, "dec");
    chk("dec_strb", 64'(strb), 64'd0);
    chk("dec_req",  64'(imem_req), 64'd0);
    @(negedge clk);
    chk("ex_strb", 64'(strb), 64'({v.ex_strb, 1'b0}));
    if (v.ex_strb[3] | v.ex_strb[2]) chk("ex_daddr", 64'(dmem_addr), 64'(v.ex_addr));
    if (v.ex_strb[1] | v.ex_strb[0]) chk("ex_saddr", 64'(stk_addr),  64'(v.ex_addr));
    chk("ex_alu", 64'(alu_op), 64'(v.instr[25:24]));
    @(negedge clk);
    chk_fields(v.instr, "wb");
    chk("wb_strb", 64'(strb), 64'({4'b0000, v.wb_we}));
    if (v.wb_we) begin
      chk("wb_waddr", 64'(rf_waddr), 64'(v.waddr));
      chk("wb_wsel",  64'(rf_wsel),  64'(v.wsel));
    end
    @(negedge clk);
    exp_pc = v.npc;
  endtask

`ifdef MIPS_CTRL_FAULT_EN
  task automatic fault_case(input logic [31:0] ins, input string tag);
    chk({tag, "_addr"}, 64'(imem_addr), 64'(exp_pc));
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    chk({tag, "_ex_strb"}, 64'(strb), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_held"}, 64'({fault, busy, imem_req, strb}), 64'({1'b1, 1'b1, 1'b0, 5'd0}));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    do_reset({tag, "_clr"});
    do_start();
  endtask
`endif

  initial begin
    vec_t v;
    logic [31:0] ins, r2;

    //             instr         r2    dly ex_strb ex_addr we  wsel waddr npc
    tbl.push_back('{32'h020A0001, 32'd0, 0, 4'b0000, 0,  1'b1, 2'd2, 4'hA, 1});
    tbl.push_back('{32'h04030102, 32'd0, 0, 4'b0000, 0,  1'b1, 2'd0, 4'h3, 2});
    tbl.push_back('{32'h080A0000, 32'd0, 1, 4'b0000, 0,  1'b0, 2'd0, 4'hA, 10});
    tbl.push_back('{32'h09060000, 32'd5, 0, 4'b0000, 0,  1'b0, 2'd0, 4'h6, 6});
    tbl.push_back('{32'h080A0000, 32'd0, 0, 4'b0000, 0,  1'b0, 2'd0, 4'hA, 10});
    tbl.push_back('{32'h09060000, 32'd0, 2, 4'b0000, 0,  1'b0, 2'd0, 4'h6, 11});
    tbl.push_back('{32'h0A000000, 32'd0, 0, 4'b0001, 0,  1'b0, 2'd0, 4'h0, 12});
    tbl.push_back('{32'h0A000000, 32'd0, 0, 4'b0001, 1,  1'b0, 2'd0, 4'h0, 13});
    tbl.push_back('{32'h0B050000, 32'd0, 0, 4'b0010, 1,  1'b1, 2'd3, 4'h5, 14});
    tbl.push_back('{32'h01020013, 32'd0, 0, 4'b1000, 19, 1'b1, 2'd1, 4'h2, 15});
    tbl.push_back('{32'h03140007, 32'd0, 0, 4'b0100, 20, 1'b0, 2'd0, 4'h4, 16});
    tbl.push_back('{32'h081F0000, 32'd0, 3, 4'b0000, 0,  1'b0, 2'd0, 4'hF, 31});
    tbl.push_back('{32'h00000000, 32'd0, 0, 4'b0000, 0,  1'b0, 2'd0, 4'h0, 0});
    tbl.push_back('{32'h0B010000, 32'd0, 0, 4'b0010, 0,  1'b1, 2'd3, 4'h1, 1});
`ifndef MIPS_CTRL_FAULT_EN
    tbl.push_back('{32'h0B000000, 32'd0, 0, 4'b0010, 31, 1'b1, 2'd3, 4'h0, 2});
    tbl.push_back('{32'h0C000000, 32'd0, 0, 4'b0000, 0,  1'b0, 2'd0, 4'h0, 3});
    tbl.push_back('{32'h0A000000, 32'd0, 0, 4'b0001, 31, 1'b0, 2'd0, 4'h0, 4});
`endif

    repeat (2) @(negedge clk);
    chk_idle("in_rst");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");
    do_start();

    foreach (tbl[i]) run_instr(tbl[i]);

    // Reset in the middle of a PUSH: no strobe, PC and SP back to zero.
    m_sp = 0;
    model(32'h0A000000, 32'd0, 0, v);
    run_instr(v);
    chk("abort_pc_nz", 64'(imem_addr != 5'd0), 64'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0A000000;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'd0;
    do_reset("abort");
    do_start();
    model(32'h0A000000, 32'd0, 0, v);
    run_instr(v);

    // Randomized instruction stream against the model.
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[31:24] = 8'($urandom_range(0, 15));
      r2 = ($urandom_range(0, 1) != 0) ? $urandom : 32'd0;
`ifdef MIPS_CTRL_FAULT_EN
      if ((ins[31:24] > 8'h0B) || ((ins[31:24] == 8'h0A) && (m_sp == 31)) ||
          ((ins[31:24] == 8'h0B) && (m_sp == 0)))
        ins[31:24] = 8'h00;
`endif
      model(ins, r2, $urandom_range(0, 3), v);
      run_instr(v);
    end

`ifdef MIPS_CTRL_FAULT_EN
    do_reset("pre_flt");
    do_start();
    fault_case(32'h0B000000, "flt_pop");
    fault_case(32'h0C000000, "flt_op");
    for (int k = 0; k < 31; k++) begin
      model(32'h0A000000, 32'd0, 0, v);
      run_instr(v);
    end
    fault_case(32'h0A000000, "flt_push");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 5, defining program-counter and instruction-address width.
REQ-002 The block SHALL have parameter SP_W, default 5, defining stack-pointer width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: pulse leaves IDLE; ignored otherwise.
REQ-006 The block SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-007 The block SHALL have port imem_addr, output, PC_W bits: fetch address, equal to the PC.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: fetch complete; imem_rdata valid this cycle.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: instruction {opcode[31:24], dest[23:16], src1[15:8], src2[7:0]}.
REQ-010 The block SHALL have ports rf_raddr1 and rf_raddr2, output, 4 bits each: register read addresses, src1[3:0] and src2[3:0].
REQ-011 The block SHALL have port rf_rdata2, input, 32 bits: register[rf_raddr2], used for the JMP0 test.
REQ-012 The block SHALL have port alu_op, output, 2 bits: 00 ADD, 01 SUB, 10 XOR, 11 AND.
REQ-013 The block SHALL have ports rf_we (output, 1 bit), rf_waddr (output, 4 bits, dest[3:0]) and rf_wsel (output, 2 bits: 0 ALU, 1 data memory, 2 immediate, 3 stack).
REQ-014 The block SHALL have port imm, output, 8 bits: the src2 field.
REQ-015 The block SHALL have ports dmem_addr (output, 5 bits), dmem_re (output, 1 bit) and dmem_we (output, 1 bit): data-memory access.
REQ-016 The block SHALL have ports stk_addr (output, SP_W bits), stk_re (output, 1 bit) and stk_we (output, 1 bit): stack access.
REQ-017 The block SHALL have ports busy (output, 1 bit, state not IDLE) and fault (output, 1 bit).

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and FAULT; IDLE->FETCH on start; FETCH->DECODE on imem_ack; DECODE->EXEC->WB->FETCH unconditionally.
REQ-019 imem_req SHALL be 1 throughout FETCH, with imem_addr stable until imem_ack; imem_rdata SHALL be latched into the instruction register on the ack cycle.
REQ-020 Every opcode SHALL take 4 cycles (FETCH, DECODE, EXEC, WB) when ack arrives in the first FETCH cycle, plus 1 cycle per ack-wait cycle.
REQ-021 rf_raddr1, rf_raddr2, alu_op and imm SHALL be driven from the instruction register in DECODE, EXEC and WB.
REQ-022 In EXEC, LOAD (0x1) SHALL assert dmem_re with dmem_addr=src2[4:0]; STR (0x3) SHALL assert dmem_we with dmem_addr=dest[4:0] (data = register[src2]).
REQ-023 In EXEC, PUSH (0xA) SHALL assert stk_we with stk_addr=SP, then SP<=SP+1; POP (0xB) SHALL assert stk_re with stk_addr=SP-1, then SP<=SP-1.
REQ-024 In WB, rf_we SHALL pulse for one cycle with rf_wsel=1 for LOAD, 2 for LDNM (0x2), 0 for ADD/SUB/XOR/AND (0x4-0x7) and 3 for POP.
REQ-025 In WB, PC SHALL update to: dest[PC_W-1:0] for JMP (0x8); dest[PC_W-1:0] for JMP0 (0x9) when rf_rdata2!=0, else PC+1; PC+1 for all other opcodes.
REQ-026 PC+1 SHALL wrap modulo 2^PC_W (31->0 at default).
REQ-027 NOOP (0x0) SHALL assert no strobes, and all strobes (rf_we, dmem_re/we, stk_re/we) SHALL be single-cycle, mutually exclusive and 0 outside the states named above.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE, PC=0, SP=0, instruction register 0 and all outputs 0, aborting any instruction without further strobes.

Configuration
REQ-029 With macro MIPS_CTRL_FAULT_EN defined, PUSH at SP=2^SP_W-1, POP at SP=0, or opcode >0xB SHALL enter FAULT in EXEC with no strobe, set fault=1 and leave FAULT only on rst.
REQ-030 Without MIPS_CTRL_FAULT_EN, SP SHALL wrap modulo 2^SP_W, opcodes >0xB SHALL execute as NOOP, and fault SHALL be tied to 0.

Verification
REQ-031 Reset, start, rdata=0x020A0001 with immediate ack -> WB: rf_we=1, rf_waddr=10, rf_wsel=2, imm=0x01; next imem_addr=1.
REQ-032 rdata=0x04030102 -> EXEC/WB: alu_op=00, rf_raddr1=1, rf_raddr2=2; WB: rf_we=1, rf_waddr=3, rf_wsel=0.
REQ-033 JMP0 rdata=0x09060000 at PC=10: rf_rdata2=5 -> next imem_addr=6; rf_rdata2=0 -> next imem_addr=11.
REQ-034 PUSH, PUSH, POP from SP=0 -> stk_we at addr 0 then 1, stk_re at addr 1, final SP=1, POP WB rf_wsel=3.
REQ-035 imem_ack delayed 3 cycles -> imem_req high and imem_addr stable for 4 cycles; NOOP at PC=31 -> next imem_addr=0.
REQ-036 POP at SP=0 -> with MIPS_CTRL_FAULT_EN: fault=1, no strobes until rst; without: stk_re at addr 31, SP=31.
